// File: rtl/med_cmd_rx.sv
// Serial command receiver: 8N1 UART deserialiser (optionally inverted line)
// feeding a two-byte "+d" / "-d" command parser with one-hot slot select.
module med_cmd_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter bit RX_INVERT    = 1'b1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       cmd_valid,
   output logic       cmd_inc,
   output logic [9:0] cmd_slot,
   output logic       cmd_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_MARK} rx_state_t;
   typedef enum logic {P_OP, P_DIGIT} p_state_t;

   rx_state_t     r_rx_state;
   p_state_t      r_p_state;
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic          r_inc;

   logic          w_line;
   logic [7:0]    w_digit;
   logic          w_is_digit;
   logic          w_is_blank;
   logic [9:0]    w_slot;

   // Synchroniser resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_sync <= {2{~RX_INVERT}};
      else        r_sync <= {r_sync[0], rxd};
   end

   assign w_line = r_sync[1] ^ RX_INVERT;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_rx_state <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         rx_byte    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (r_rx_state)
            S_IDLE: begin
               if (!w_line) begin
                  r_cnt      <= '0;
                  r_rx_state <= S_START;
               end
            end
            S_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt      <= '0;
                  r_idx      <= '0;
                  r_rx_state <= w_line ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt   <= '0;
                  r_shift <= {w_line, r_shift[7:1]};
                  if (r_idx == 3'd7) r_rx_state <= S_STOP;
                  else               r_idx      <= r_idx + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt <= '0;
                  if (w_line) begin
                     rx_byte    <= r_shift;
                     rx_valid   <= 1'b1;
                     r_rx_state <= S_IDLE;
                  end else begin
                     frame_err  <= 1'b1;
                     r_rx_state <= S_WAIT_MARK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_MARK: begin
               // A held break must return to mark before another start is seen.
               if (w_line) r_rx_state <= S_IDLE;
            end
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

   assign w_digit    = rx_byte - 8'h30;
   assign w_is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
   assign w_is_blank = (rx_byte == 8'h0D) || (rx_byte == 8'h0A) || (rx_byte == 8'h20);

   for (genvar gi = 0; gi < 10; gi++) begin : g_slot
      assign w_slot[gi] = (w_digit == 8'(gi));
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_p_state <= P_OP;
         r_inc     <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_inc   <= 1'b0;
         cmd_slot  <= '0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         cmd_err   <= 1'b0;
         if (frame_err) begin
            r_p_state <= P_OP;
         end else if (rx_valid) begin
            case (r_p_state)
               P_OP: begin
                  if (rx_byte == 8'h2B) begin
                     r_inc     <= 1'b1;
                     r_p_state <= P_DIGIT;
                  end else if (rx_byte == 8'h2D) begin
                     r_inc     <= 1'b0;
                     r_p_state <= P_DIGIT;
                  end else if (!w_is_blank) begin
                     cmd_err <= 1'b1;
                  end
               end
               P_DIGIT: begin
                  if (w_is_digit) begin
                     cmd_slot  <= w_slot;
                     cmd_inc   <= r_inc;
                     cmd_valid <= 1'b1;
                     r_p_state <= P_OP;
                  end else if (rx_byte == 8'h2B || rx_byte == 8'h2D) begin
                     // A fresh operator restarts the command rather than aborting it.
                     cmd_err <= 1'b1;
                     r_inc   <= (rx_byte == 8'h2B);
                  end else begin
                     cmd_err   <= 1'b1;
                     r_p_state <= P_OP;
                  end
               end
               default: r_p_state <= P_OP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_med_cmd_rx.sv
// Bench for med_cmd_rx: inverted and idle-high instances share one line stimulus
// and are compared against a byte-level command model via event queues.
module tb_med_cmd_rx;

   localparam int CPB = 16;

   typedef struct packed {
      logic [1:0] kind;   // 0 rx byte, 1 frame error, 2 command, 3 command error
      logic [7:0] b;
      logic       inc;
      logic [9:0] slot;
   } ev_t;

   logic clk = 1'b0;
   logic n_rst;
   logic tb_line;

   logic [7:0] rx_byte_w   [2];
   logic       rx_valid_w  [2];
   logic       frame_err_w [2];
   logic       cmd_valid_w [2];
   logic       cmd_inc_w   [2];
   logic [9:0] cmd_slot_w  [2];
   logic       cmd_err_w   [2];
   logic       prev_rxv    [2];

   ev_t exp_q[$];
   ev_t obs0[$];
   ev_t obs1[$];

   int checks   = 0;
   int failures = 0;

   bit         m_digit;
   bit         m_inc;
   logic [7:0] m_last;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic w_rxd;
      assign w_rxd = (gi == 0) ? ~tb_line : tb_line;
      med_cmd_rx #(
         .CLKS_PER_BIT(CPB),
         .RX_INVERT   ((gi == 0) ? 1'b1 : 1'b0)
      ) u_dut (
         .clk      (clk),
         .n_rst    (n_rst),
         .rxd      (w_rxd),
         .rx_byte  (rx_byte_w[gi]),
         .rx_valid (rx_valid_w[gi]),
         .frame_err(frame_err_w[gi]),
         .cmd_valid(cmd_valid_w[gi]),
         .cmd_inc  (cmd_inc_w[gi]),
         .cmd_slot (cmd_slot_w[gi]),
         .cmd_err  (cmd_err_w[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_obs(input int d, input ev_t e);
      if (d == 0) obs0.push_back(e);
      else        obs1.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (n_rst) begin
            if (rx_valid_w[d])  push_obs(d, ev_t'({2'd0, rx_byte_w[d], 1'b0, 10'd0}));
            if (frame_err_w[d]) push_obs(d, ev_t'({2'd1, 8'd0, 1'b0, 10'd0}));
            if (cmd_valid_w[d]) push_obs(d, ev_t'({2'd2, 8'd0, cmd_inc_w[d], cmd_slot_w[d]}));
            if (cmd_err_w[d])   push_obs(d, ev_t'({2'd3, 8'd0, 1'b0, 10'd0}));
            if (cmd_valid_w[d] || cmd_err_w[d]) begin
               check("cmd_one_cycle_after_rx_valid", 32'(prev_rxv[d]), 32'd1);
               check("cmd_valid_err_exclusive", 32'(cmd_valid_w[d] & cmd_err_w[d]), 32'd0);
            end
            if (rx_valid_w[d]) begin
               check("rx_valid_single_cycle", 32'(prev_rxv[d]), 32'd0);
               check("rx_valid_ferr_exclusive", 32'(frame_err_w[d]), 32'd0);
            end
         end
         prev_rxv[d] <= rx_valid_w[d];
      end
   end

   // Command grammar written directly at byte level.
   task automatic model_byte(input logic [7:0] b);
      m_last = b;
      exp_q.push_back(ev_t'({2'd0, b, 1'b0, 10'd0}));
      if (!m_digit) begin
         if (b == 8'h2B) begin
            m_inc = 1'b1; m_digit = 1'b1;
         end else if (b == 8'h2D) begin
            m_inc = 1'b0; m_digit = 1'b1;
         end else if (!(b == 8'h0D || b == 8'h0A || b == 8'h20)) begin
            exp_q.push_back(ev_t'({2'd3, 8'd0, 1'b0, 10'd0}));
         end
      end else begin
         if (b >= 8'h30 && b <= 8'h39) begin
            exp_q.push_back(ev_t'({2'd2, 8'd0, m_inc, 10'd1 << (b - 8'h30)}));
            m_digit = 1'b0;
         end else if (b == 8'h2B || b == 8'h2D) begin
            exp_q.push_back(ev_t'({2'd3, 8'd0, 1'b0, 10'd0}));
            m_inc = (b == 8'h2B);
         end else begin
            exp_q.push_back(ev_t'({2'd3, 8'd0, 1'b0, 10'd0}));
            m_digit = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      tb_line = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      drive(stop_ok, CPB);
      if (stop_ok) begin
         model_byte(b);
      end else begin
         exp_q.push_back(ev_t'({2'd1, 8'd0, 1'b0, 10'd0}));
         m_digit = 1'b0;
      end
   endtask

   task automatic check_events(input string tag);
      ev_t o0, o1;
      drive(1'b1, 3 * CPB);
      check({tag, "_count_inv"}, 32'(obs0.size()), 32'(exp_q.size()));
      check({tag, "_count_std"}, 32'(obs1.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         o0 = (i < obs0.size()) ? obs0[i] : '1;
         o1 = (i < obs1.size()) ? obs1[i] : '1;
         check($sformatf("%s_ev%0d_inv", tag, i), 32'(o0), 32'(exp_q[i]));
         check($sformatf("%s_ev%0d_std", tag, i), 32'(o1), 32'(exp_q[i]));
      end
      for (int d = 0; d < 2; d++) check({tag, "_rx_byte"}, 32'(rx_byte_w[d]), 32'(m_last));
      exp_q.delete();
      obs0.delete();
      obs1.delete();
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_rx_byte"},   32'(rx_byte_w[d]),   32'd0);
         check({tag, "_rx_valid"},  32'(rx_valid_w[d]),  32'd0);
         check({tag, "_frame_err"}, 32'(frame_err_w[d]), 32'd0);
         check({tag, "_cmd_valid"}, 32'(cmd_valid_w[d]), 32'd0);
         check({tag, "_cmd_inc"},   32'(cmd_inc_w[d]),   32'd0);
         check({tag, "_cmd_slot"},  32'(cmd_slot_w[d]),  32'd0);
         check({tag, "_cmd_err"},   32'(cmd_err_w[d]),   32'd0);
      end
   endtask

   initial begin
      logic [7:0] pool [12];
      logic [7:0] plus;
      logic [7:0] b;
      pool = '{8'h2B, 8'h2D, 8'h30, 8'h31, 8'h35, 8'h39, 8'h0D, 8'h0A, 8'h20, 8'h41, 8'h7A, 8'h2F};
      plus = 8'h2B;
      m_digit = 1'b0; m_inc = 1'b0; m_last = 8'h00;
      n_rst = 1'b0;
      tb_line = 1'b1;
      repeat (5) @(negedge clk);
      check_zero("reset");
      n_rst = 1'b1;
      drive(1'b1, 2 * CPB);

      // "+3" back-to-back
      send_frame(8'h2B, 1'b1);
      send_frame(8'h33, 1'b1);
      check_events("plus3");

      // "-9\r\n"
      send_frame(8'h2D, 1'b1);
      send_frame(8'h39, 1'b1);
      send_frame(8'h0D, 1'b1);
      send_frame(8'h0A, 1'b1);
      check_events("minus9_crlf");

      // short space glitch, then a real frame
      drive(1'b0, 4);
      drive(1'b1, 2 * CPB);
      check_events("glitch");
      send_frame(8'h35, 1'b1);
      check_events("after_glitch");

      // framing error with a held break
      send_frame(8'h41, 1'b0);
      drive(1'b0, 40);
      drive(1'b1, CPB);
      check_events("frame_err");
      send_frame(8'h35, 1'b1);
      check_events("digit_in_op");

      // "+A" then "++0"
      send_frame(8'h2B, 1'b1);
      send_frame(8'h41, 1'b1);
      check_events("plusA");
      send_frame(8'h2B, 1'b1);
      send_frame(8'h2B, 1'b1);
      send_frame(8'h30, 1'b1);
      check_events("plusplus0");

      // reset in the middle of data bit 4 of '+'
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(plus[i], CPB);
      drive(plus[4], CPB / 2);
      n_rst = 1'b0;
      tb_line = 1'b1;
      @(negedge clk);
      check_zero("mid_frame_reset");
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      m_digit = 1'b0; m_inc = 1'b0; m_last = 8'h00;
      exp_q.delete(); obs0.delete(); obs1.delete();
      check_events("after_reset");
      send_frame(8'h2D, 1'b1);
      send_frame(8'h31, 1'b1);
      check_events("minus1");

      // randomized traffic, occasional framing errors and variable gaps
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
         else                           b = pool[$urandom_range(0, 11)];
         if ($urandom_range(0, 9) == 0) begin
            send_frame(b, 1'b0);
            drive(1'b0, $urandom_range(0, 30));
            drive(1'b1, CPB);
         end else begin
            send_frame(b, 1'b1);
         end
         drive(1'b1, $urandom_range(0, 20));
         if (n % 15 == 14) check_events($sformatf("random_%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
